jpeg_byte_streamer: RTL and testbench
=====================================

# jpeg_byte_streamer

Byte-stream source for the JPEG decoder's parser input. On `start` it reads a compressed JPEG file from a synchronous byte memory, beginning at `base_addr`. It then drives `byte_out`/`byte_valid` under the parser's `parser_ready` backpressure, sustaining one byte per clock. It stops after `length` bytes or on the EOI marker (FF D9), whichever comes first, and reports completion. It sits between the bitstream memory and `jpeg_decoder_top`'s `byte_in`/`byte_valid`/`parser_ready` port.

## Interface
- `ADDR_W`, 16, memory address width; max stream 2^ADDR_W bytes
- `clk` input 1 — single clock, rising edge
- `rst` input 1 — asynchronous, active-high reset
- `start` input 1 — begin streaming; sampled only in IDLE
- `base_addr` input ADDR_W — first byte address; latched at start
- `length` input ADDR_W+1 — byte count; latched at start; 0 means 2^ADDR_W
- `mem_en` output 1 — read strobe
- `mem_addr` output ADDR_W — read address
- `mem_rdata` input 8 — read data, valid exactly 1 cycle after `mem_en`
- `byte_out` output 8 — stream byte to parser
- `byte_valid` output 1 — `byte_out` holds a valid byte
- `parser_ready` input 1 — parser accepts; transfer = `byte_valid && parser_ready` at rising `clk`
- `busy` output 1 — high from start until completion
- `done` output 1 — one-cycle completion pulse
- `eoi_seen` output 1 — sticky: stream ended on FF D9; cleared at next start
- `byte_count` output ADDR_W+1 — bytes transferred since last start

## Operation
- **Reset values:** all outputs are 0; state is IDLE; FIFO, in-flight flag, counters and previous-byte register are cleared.
- **IDLE → STREAM on `start`:**
  - latch `base_addr` and `length`
  - clear `byte_count` and `eoi_seen`
  - set `busy`
  - `start` is ignored outside IDLE.
- **STREAM:**
  - A 2-entry FIFO buffers read data. One in-flight flag tracks the outstanding read.
  - Issue a read (`mem_en`=1, `mem_addr`=next address) when all three hold:
    - `issued < length`
    - no stop is pending
    - `fifo_count + inflight − pop < 2`, where pop is the current-cycle transfer
  - The address increments per issued read and wraps modulo 2^ADDR_W.
  - `mem_rdata` is pushed into the FIFO in the cycle after `mem_en`.
  - `byte_out` is the FIFO head; `byte_valid` = FIFO not empty.
  - `byte_out` holds stable while `byte_valid && !parser_ready`.
- **Per transfer:** `byte_count`++; `prev_ff` ← (`byte_out` == 8'hFF).
- **EOI:**
  - Detected when a transfer carries 8'hD9 with `prev_ff`=1. FF FF D9 terminates; FF 00 D9 does not.
  - On detection: set `eoi_seen`, stop issuing, discard FIFO contents and any in-flight return, go to FINISH.
- **Length end:** when `byte_count` reaches `length` (the last issued byte transferred) → FINISH.
- **EOI on the final length byte:** EOI wins; `eoi_seen`=1.
- **FINISH:**
  - `done`=1 for one cycle; `busy`=0; `byte_valid`=0
  - next state IDLE
  - a `start` in the FINISH cycle is ignored.
- **Reset mid-stream:** everything returns immediately to reset values. No `done` is produced.

## Timing
- **Start latency:**
  - `start` sampled at edge T
  - `mem_en` high in cycle T+1
  - first `byte_valid` in cycle T+2
- **Throughput:** with `parser_ready` held high, one transfer per cycle with no bubbles.
- **Backpressure:**
  - `parser_ready` low for N cycles → at most 2 bytes buffered, no reads issued beyond FIFO space.
  - Transfers resume in the cycle `parser_ready` returns.
- **Completion:** `done` and `busy`=0 in the cycle after the terminating transfer.
- **Minimum spacing:** from one `start` to the next accepted `start` is length+3 cycles at full rate.
- **Discarded read:** an in-flight read discarded at EOI never reaches `byte_out`.

## Configuration
- **`JPEG_STREAMER_EOI_STOP_EN` defined:** EOI detection and early stop as described; `eoi_seen` is functional.
- **Not defined:** only `length` terminates the stream; `eoi_seen` is tied 0; `prev_ff` logic is removed.

## Test plan
- **Full-rate run:** `base_addr`=0x0010, `length`=5, memory holds 11 22 33 44 55, `parser_ready`=1 → `byte_valid` cycles T+2..T+6 carry 11..55; `done` at T+7; `byte_count`=5; `eoi_seen`=0.
- **Backpressure:** same data, `parser_ready` toggles 1,0,0,1,… → the byte sequence is unchanged, `byte_out` is stable while stalled, and `mem_en` is never asserted with 2 bytes buffered plus one in flight.
- **EOI stop (macro on):** memory FF D8 00 FF D9 AA BB, `length`=7 → 5 transfers, AA never output; `done` follows; `eoi_seen`=1; `byte_count`=5.
- **Stuffing/padding (macro on):** FF 00 D9 07 FF FF D9 → no stop at D9 after 00; stop after the final D9; `byte_count`=7.
- **Macro off:** the EOI test data streams all 7 bytes; `eoi_seen`=0.
- **Reset mid-stream and address wrap:**
  - Reset after 3 of 10 bytes → all outputs 0, no `done`; a new start with `base_addr`=0xFFFE, `length`=4 reads addresses FFFE, FFFF, 0000, 0001.
  - `length`=0 with `ADDR_W`=4 → 16 bytes then `done`.

Source files
------------

// File: rtl/jpeg_byte_streamer.sv
// jpeg_byte_streamer
// Streams a compressed JPEG file from a synchronous byte memory into the
// decoder's parser input, one byte per clock under parser backpressure.
// A two-entry buffer plus one outstanding read keep the stream running at
// full rate. The read returning in the current cycle is presented directly
// as the stream head when the buffer is empty.
//
// Optional feature macro: JPEG_STREAMER_EOI_STOP_EN
//   defined   -> a transferred FF D9 pair ends the stream early, eoi_seen works
//   undefined -> only the byte count ends the stream, eoi_seen is tied low
//
// Ports
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   start               : begin streaming (accepted only when idle)
//   base_addr, length   : first address and byte count, latched at start
//                         (length 0 means 2^ADDR_W bytes)
//   mem_en, mem_addr    : memory read strobe and address
//   mem_rdata           : read data, valid the cycle after mem_en
//   byte_out/byte_valid : stream byte to the parser
//   parser_ready        : parser accepts the byte this cycle
//   busy, done          : streaming in progress / one-cycle completion pulse
//   eoi_seen            : stream ended on an EOI marker (sticky until start)
//   byte_count          : bytes transferred since the last start
module jpeg_byte_streamer #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              parser_ready,
    output logic              busy,
    output logic              done,
    output logic              eoi_seen,
    output logic [ADDR_W:0]   byte_count
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    localparam logic [ADDR_W:0]   LEN_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LEN_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   issued_q, issued_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [1:0]        fcnt_q, fcnt_d;
    logic [7:0]        fifo0_q, fifo0_d;
    logic [7:0]        fifo1_q, fifo1_d;
    logic              inflight_q, inflight_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              streaming_s;
    logic              valid_s;
    logic [7:0]        head_s;
    logic              xfer_s;
    logic              last_s;
    logic              eoi_s;
    logic              stop_s;
    logic [2:0]        occ_s;
    logic              issue_s;
    logic              pop_s;
    logic              push_s;

`ifdef JPEG_STREAMER_EOI_STOP_EN
    logic              prev_ff_q, prev_ff_d;
    logic              eoi_seen_q, eoi_seen_d;
`endif

    assign streaming_s = (state_q == ST_STREAM);

    // The returning read counts as buffered data so the first byte appears
    // one cycle after its read strobe and full rate needs no extra entry.
    assign valid_s = streaming_s && ((fcnt_q != 2'd0) || inflight_q);
    assign head_s  = (fcnt_q != 2'd0) ? fifo0_q : mem_rdata;
    assign xfer_s  = valid_s && parser_ready;
    assign last_s  = xfer_s && ((count_q + LEN_ONE) == len_q);

`ifdef JPEG_STREAMER_EOI_STOP_EN
    assign eoi_s = xfer_s && prev_ff_q && (head_s == 8'hD9);
`else
    assign eoi_s = 1'b0;
`endif

    assign stop_s = last_s || eoi_s;

    // Occupancy after this cycle's transfer; a valid transfer implies at
    // least one byte is held, so the subtraction cannot underflow.
    assign occ_s   = {1'b0, fcnt_q} + {2'b00, inflight_q} - {2'b00, xfer_s};
    assign issue_s = streaming_s && (issued_q < len_q) && !stop_s && (occ_s < 3'd2);

    // A bypassed return (buffer empty, byte taken at once) is never stored.
    assign pop_s  = xfer_s && (fcnt_q != 2'd0);
    assign push_s = inflight_q && !(xfer_s && (fcnt_q == 2'd0));

    // Buffer and outstanding-read tracking; a stop discards both.
    always_comb begin
        fifo0_d    = fifo0_q;
        fifo1_d    = fifo1_q;
        fcnt_d     = fcnt_q;
        inflight_d = issue_s;
        if (!streaming_s || stop_s) begin
            fcnt_d = 2'd0;
        end else begin
            if (pop_s) begin
                fifo0_d = fifo1_q;
                fcnt_d  = fcnt_q - 2'd1;
            end else begin
                fcnt_d = fcnt_q;
            end
            if (push_s) begin
                if (fcnt_d == 2'd0) begin
                    fifo0_d = mem_rdata;
                end else begin
                    fifo1_d = mem_rdata;
                end
                fcnt_d = fcnt_d + 2'd1;
            end else begin
                fcnt_d = fcnt_d;
            end
        end
    end

    // Control state machine, read address generation and counters.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        issued_d = issued_q;
        count_d  = count_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef JPEG_STREAMER_EOI_STOP_EN
        prev_ff_d  = prev_ff_q;
        eoi_seen_d = eoi_seen_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_STREAM;
                    addr_d   = base_addr;
                    len_d    = (length == LEN_ZERO) ? LEN_FULL : length;
                    issued_d = LEN_ZERO;
                    count_d  = LEN_ZERO;
                    busy_d   = 1'b1;
`ifdef JPEG_STREAMER_EOI_STOP_EN
                    prev_ff_d  = 1'b0;
                    eoi_seen_d = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (issue_s) begin
                    addr_d   = addr_q + ADDR_ONE;
                    issued_d = issued_q + LEN_ONE;
                end else begin
                    addr_d   = addr_q;
                    issued_d = issued_q;
                end
                if (xfer_s) begin
                    count_d = count_q + LEN_ONE;
`ifdef JPEG_STREAMER_EOI_STOP_EN
                    prev_ff_d = (head_s == 8'hFF);
`endif
                end else begin
                    count_d = count_q;
                end
                if (stop_s) begin
                    state_d = ST_FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`ifdef JPEG_STREAMER_EOI_STOP_EN
                    eoi_seen_d = eoi_s;
`endif
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= {ADDR_W{1'b0}};
            len_q      <= LEN_ZERO;
            issued_q   <= LEN_ZERO;
            count_q    <= LEN_ZERO;
            fcnt_q     <= 2'd0;
            fifo0_q    <= 8'h00;
            fifo1_q    <= 8'h00;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            count_q    <= count_d;
            fcnt_q     <= fcnt_d;
            fifo0_q    <= fifo0_d;
            fifo1_q    <= fifo1_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef JPEG_STREAMER_EOI_STOP_EN
    // Marker tracking registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_ff_q  <= 1'b0;
            eoi_seen_q <= 1'b0;
        end else begin
            prev_ff_q  <= prev_ff_d;
            eoi_seen_q <= eoi_seen_d;
        end
    end

    assign eoi_seen = eoi_seen_q;
`else
    assign eoi_seen = 1'b0;
`endif

    assign mem_en     = issue_s;
    assign mem_addr   = addr_q;
    assign byte_out   = valid_s ? head_s : 8'h00;
    assign byte_valid = valid_s;
    assign busy       = busy_q;
    assign done       = done_q;
    assign byte_count = count_q;

endmodule

// File: tb/tb_jpeg_byte_streamer.sv
module tb_jpeg_byte_streamer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, mem_en, byte_valid, parser_ready, busy, done, eoi_seen;
    logic [15:0] base_addr, mem_addr;
    logic [16:0] length, byte_count;
    logic [7:0]  mem_rdata, byte_out;

    logic        s4, me4, bv4, pr4, busy4, done4, eoi4;
    logic [3:0]  b4, ma4;
    logic [4:0]  l4, bc4;
    logic [7:0]  rd4, bo4;

    logic [7:0]  mem [0:65535];

    int checks = 0;
    int failures = 0;

    jpeg_byte_streamer #(.ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .byte_out(byte_out), .byte_valid(byte_valid), .parser_ready(parser_ready),
        .busy(busy), .done(done), .eoi_seen(eoi_seen), .byte_count(byte_count)
    );

    jpeg_byte_streamer #(.ADDR_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(s4), .base_addr(b4), .length(l4),
        .mem_en(me4), .mem_addr(ma4), .mem_rdata(rd4),
        .byte_out(bo4), .byte_valid(bv4), .parser_ready(pr4),
        .busy(busy4), .done(done4), .eoi_seen(eoi4), .byte_count(bc4)
    );

    // synchronous memories: data valid the cycle after the strobe, garbage otherwise
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
        else        mem_rdata <= 8'($urandom);
        if (me4)    rd4 <= {4'h5, ma4};
        else        rd4 <= 8'($urandom);
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // reference model: bytes the parser should receive
    logic [7:0] exp_q[$];
    bit         exp_eoi;

    function automatic void build_expected(input logic [15:0] base, input int n);
        logic [7:0] b;
        logic [7:0] prev;
        exp_q.delete();
        exp_eoi = 1'b0;
        prev = 8'h00;
        for (int i = 0; i < n; i++) begin
            b = mem[16'(base + i)];
            exp_q.push_back(b);
`ifdef JPEG_STREAMER_EOI_STOP_EN
            if (prev == 8'hFF && b == 8'hD9) begin
                exp_eoi = 1'b1;
                break;
            end
`endif
            prev = b;
        end
    endfunction

    // monitor state
    bit          mon_en = 1'b0;
    int          xfer_n, issue_n, cyc, first_en_cyc, done_n, done_cyc, eff_len;
    logic [15:0] mon_base;
    logic [7:0]  stall_byte;
    bit          stall_pend;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cyc++;
                if (stall_pend && byte_valid) check_val("stall_hold", byte_out, stall_byte);
                if (mem_en) begin
                    check_val("mem_addr", mem_addr, 16'(mon_base + issue_n));
                    check_val("issue_bound", (issue_n < eff_len), 1);
                    check_val("issue_space",
                              ((issue_n - xfer_n - int'(byte_valid && parser_ready)) < 2), 1);
                    if (first_en_cyc < 0) first_en_cyc = cyc;
                    issue_n++;
                end
                if (byte_valid && parser_ready) begin
                    if (xfer_n < exp_q.size()) check_val("byte", byte_out, exp_q[xfer_n]);
                    else check_val("xfer_overrun", xfer_n, exp_q.size());
                    xfer_n++;
                end
                stall_pend = byte_valid && !parser_ready;
                stall_byte = byte_out;
                if (done) begin
                    done_n++;
                    done_cyc = cyc;
                end
            end
        end
    end

    function automatic logic pr_val(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 3 == 0);
            default: return ($urandom_range(0, 3) != 0);
        endcase
    endfunction

    task automatic run_stream(input logic [15:0] b, input logic [16:0] l, input int mode,
                              input bit poke);
        int n;
        bit timeout;
        n = (l == 17'd0) ? 65536 : int'(l);
        build_expected(b, n);
        mon_base = b; eff_len = n; xfer_n = 0; issue_n = 0; cyc = 0;
        first_en_cyc = -1; done_n = 0; done_cyc = -1; stall_pend = 1'b0;
        @(posedge clk); #1;
        base_addr = b; length = l; start = 1'b1; parser_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = 16'($urandom);
        length = 17'($urandom);
        parser_ready = pr_val(mode, 0);
        mon_en = 1'b1;
        timeout = 1'b1;
        for (int k = 1; k < 4 * n + 20; k++) begin
            @(negedge clk); #1;
            if (done) begin
                timeout = 1'b0;
                break;
            end
            @(posedge clk); #1;
            parser_ready = pr_val(mode, k);
            start = poke && (k == 3);
        end
        check_val("timeout", timeout, 0);
        check_val("xfer_total", xfer_n, exp_q.size());
        check_val("byte_count", byte_count, exp_q.size());
        check_val("eoi_seen", eoi_seen, exp_eoi);
        check_val("busy_at_done", busy, 0);
        check_val("valid_at_done", byte_valid, 0);
        if (mode == 0) begin
            check_val("start_latency", first_en_cyc, 1);
            check_val("done_latency", done_cyc, exp_q.size() + 2);
        end
        start = 1'b1;  // arrives in the completion cycle and must be ignored
        @(posedge clk); #1;
        start = 1'b0;
        check_val("finish_start_ignored", busy, 0);
        check_val("done_pulse", done, 0);
        @(negedge clk); #1;
        check_val("done_count", done_n, 1);
        mon_en = 1'b0;
    endtask

    function automatic void fill_random(input logic [15:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0:       mem[16'(b + i)] = 8'hFF;
                1:       mem[16'(b + i)] = 8'hD9;
                2:       mem[16'(b + i)] = 8'h00;
                default: mem[16'(b + i)] = 8'($urandom);
            endcase
        end
    endfunction

    initial begin
        int n4, got;
        logic [7:0] d1 [7];
        logic [7:0] d2 [7];
        logic [7:0] d3 [5];
        logic [15:0] rb;
        d1 = '{8'hFF, 8'hD8, 8'h00, 8'hFF, 8'hD9, 8'hAA, 8'hBB};
        d2 = '{8'hFF, 8'h00, 8'hD9, 8'h07, 8'hFF, 8'hFF, 8'hD9};
        d3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        rst = 1'b1; start = 1'b0; parser_ready = 1'b0;
        base_addr = 16'h0000; length = 17'd0;
        s4 = 1'b0; b4 = 4'h0; l4 = 5'd0; pr4 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_mem_en", mem_en, 0);
        check_val("rst_mem_addr", mem_addr, 0);
        check_val("rst_valid", byte_valid, 0);
        check_val("rst_byte_out", byte_out, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_eoi", eoi_seen, 0);
        check_val("rst_count", byte_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) mem[16'h0010 + i] = d3[i];
        run_stream(16'h0010, 17'd5, 0, 1'b0);
        run_stream(16'h0010, 17'd5, 1, 1'b0);
        for (int i = 0; i < 7; i++) mem[16'h0100 + i] = d1[i];
        run_stream(16'h0100, 17'd7, 0, 1'b0);
        for (int i = 0; i < 7; i++) mem[16'h0200 + i] = d2[i];
        run_stream(16'h0200, 17'd7, 2, 1'b0);

        for (int it = 0; it < 8; it++) begin
            int rl;
            rb = 16'($urandom);
            rl = $urandom_range(1, 40);
            fill_random(rb, rl);
            run_stream(rb, 17'(rl), $urandom_range(0, 2), it[0]);
        end

        // reset in the middle of a 10-byte stream
        for (int i = 0; i < 10; i++) mem[16'h0300 + i] = 8'(8'h20 + i);
        @(posedge clk); #1;
        base_addr = 16'h0300; length = 17'd10; start = 1'b1; parser_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got = 0;
        for (int k = 0; k < 20 && got < 3; k++) begin
            @(negedge clk);
            if (byte_valid && parser_ready) got++;
        end
        check_val("pre_reset_xfers", got, 3);
        #1;
        rst = 1'b1;
        #1;
        check_val("mid_rst_mem_en", mem_en, 0);
        check_val("mid_rst_valid", byte_valid, 0);
        check_val("mid_rst_byte_out", byte_out, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_count", byte_count, 0);
        check_val("mid_rst_eoi", eoi_seen, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check_val("mid_rst_no_done", done, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // address wrap
        mem[16'hFFFE] = 8'h61; mem[16'hFFFF] = 8'h62;
        mem[16'h0000] = 8'h63; mem[16'h0001] = 8'h64;
        run_stream(16'hFFFE, 17'd4, 0, 1'b0);

        // length 0 on a 4-bit address build streams the full space
        @(posedge clk); #1;
        b4 = 4'hC; l4 = 5'd0; s4 = 1'b1;
        @(posedge clk); #1;
        s4 = 1'b0;
        n4 = 0;
        got = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bv4 && pr4) begin
                check_val("w4_byte", bo4, {4'h5, 4'(4'hC + n4)});
                n4++;
            end
            if (done4) begin
                got = 1;
                break;
            end
        end
        #1;
        check_val("w4_done_seen", got, 1);
        check_val("w4_xfers", n4, 16);
        check_val("w4_byte_count", bc4, 16);
        check_val("w4_eoi", eoi4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
